hvac_zone_ctrl: RTL
===================

Name: hvac_zone_ctrl

Overview:
- Parametrised multi-zone successor to the single-zone HVAC on/heat/cool/off controller.
- Each of NZ zones has an independent FSM driven by on/off/heat/cool command pulses plus a temperature/setpoint comparison with hysteresis.
- Adds compressor protection (minimum run time, post-run lockout) and per-zone status.
- Sits between the zone command/sensor front end and the actuator drivers.

Parameters:
NZ, 2, number of independent zones
TW, 8, temperature/setpoint width, unsigned
HYST, 2, hysteresis band in temperature LSBs
MIN_RUN, 16, minimum HEATING/COOLING residency in clk cycles (>=1)
LOCKOUT, 8, post-run lockout length in clk cycles (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
on_i  in  NZ  per-zone turn-on pulse
off_i  in  NZ  per-zone turn-off pulse
heat_i  in  NZ  per-zone select-heat-mode pulse
cool_i  in  NZ  per-zone select-cool-mode pulse
temp_i  in  NZ*TW  per-zone measured temperature, zone z at [z*TW +: TW]
setpt_i  in  NZ*TW  per-zone setpoint, same packing
power_o  out  NZ  zone enabled
heat_o  out  NZ  heater drive
cool_o  out  NZ  compressor drive
fan_o  out  NZ  fan drive
state_o  out  NZ*3  per-zone state code, zone z at [z*3 +: 3]

Behaviour:
- Reset (reset=0): effective immediately, with no clock edge required. Every zone goes to OFF and mode=HEAT. Counters and pending_off are cleared. All outputs are 0. state_o is all zeros.
- State codes: OFF=0, IDLE=1, HEATING=2, COOLING=3, LOCKOUT=4.
- Outputs are registered and decoded from the next state, so they change on the same edge as the state.
  - power_o=1 in every state except OFF.
  - heat_o=1 only in HEATING; cool_o=1 only in COOLING.
  - fan_o=1 in HEATING, COOLING and LOCKOUT (purge).
- Mode register: heat_i sets HEAT and cool_i sets COOL in any state. If both are asserted in the same cycle, cool wins.
- Thresholds, unsigned:
  - lo = setpt - HYST, saturating at 0.
  - hi = setpt + HYST, saturating at 2^TW-1.
- Transitions (per zone; off has priority over on):
  - OFF: on_i=1 and off_i=0 -> IDLE.
  - IDLE:
    - off_i -> OFF.
    - mode=HEAT and temp <= lo -> HEATING.
    - mode=COOL and temp >= hi -> COOLING.
    - Conditions are evaluated on the mode register value before this cycle's update.
  - HEATING/COOLING:
    - run_cnt clears on entry and increments each cycle, saturating.
    - off_i -> LOCKOUT immediately, overriding MIN_RUN, with pending_off=1.
    - Otherwise exit to LOCKOUT once run_cnt >= MIN_RUN-1 and any of the following holds: (HEATING and temp >= setpt), (COOLING and temp <= setpt), or the mode no longer matches the state.
  - LOCKOUT:
    - lock_cnt clears on entry. After LOCKOUT cycles in the state: go to OFF if pending_off, else IDLE.
    - off_i sets pending_off; on_i clears it. If both arrive in the same cycle, off wins.
- Latency:
  - A command sampled at edge k is visible on the outputs after edge k.
  - IDLE->HEATING/COOLING takes at least one cycle after entering IDLE.
- Zones are fully independent; there are no shared resources.
- Counter width is $clog2(max(MIN_RUN,LOCKOUT)+1).

Test Plan:
Bench overrides: NZ=2, TW=8, HYST=2, MIN_RUN=4, LOCKOUT=3.
1. Assert reset low mid-cycle with zone0 in HEATING -> all outputs 0 and state_o=0 before the next clk edge; after release, on_i stays idle -> zone remains OFF.
2. Zone0: setpt=70, temp=68 (=lo), pulse on_i -> IDLE (power=1) after 1 edge, HEATING (heat=1, fan=1) after the next. Set temp=70 at the first HEATING cycle -> heat held for exactly 4 cycles, then LOCKOUT for 3 cycles (fan=1, heat=0), then IDLE.
3. Zone0 HEATING, pulse cool_i on run cycle 1, temp=65 -> heat stays on until 4 cycles total, then LOCKOUT 3 cycles, then IDLE. With temp=72 (=hi) -> COOLING next edge, cool=1.
4. Zone0 COOLING, pulse off_i on run cycle 0 -> next edge LOCKOUT (cool=0, fan=1), 3 cycles later OFF (power=0). Repeat with on_i pulsed during LOCKOUT -> returns to IDLE instead.
5. Simultaneous events:
   - on_i+off_i in OFF -> stays OFF.
   - heat_i+cool_i in IDLE -> mode=COOL.
   - setpt=1 -> lo saturates to 0; heating starts only at temp=0.
   - setpt=254 -> hi=255.
6. Zone1 driven to COOLING while zone0 runs scenario 2 -> no cross-zone interaction on any output or state_o field.

Source files
------------

// File: rtl/hvac_zone_ctrl.sv
// hvac_zone_ctrl: multi-zone HVAC controller. Each zone has its own FSM
// (OFF/IDLE/HEATING/COOLING/LOCKOUT) with a hysteresis thermostat,
// compressor minimum run time and post-run lockout.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset
//   on_i     - per-zone turn-on pulse
//   off_i    - per-zone turn-off pulse
//   heat_i   - per-zone select-heat pulse
//   cool_i   - per-zone select-cool pulse
//   temp_i   - per-zone temperature, zone z at [z*TW +: TW]
//   setpt_i  - per-zone setpoint, same packing
//   power_o  - zone enabled (registered)
//   heat_o   - heater drive (registered)
//   cool_o   - compressor drive (registered)
//   fan_o    - fan drive (registered)
//   state_o  - per-zone state code, zone z at [z*3 +: 3]
module hvac_zone_ctrl #(
  parameter int unsigned NZ      = 2,
  parameter int unsigned TW      = 8,
  parameter int unsigned HYST    = 2,
  parameter int unsigned MIN_RUN = 16,
  parameter int unsigned LOCKOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NZ-1:0]     on_i,
  input  logic [NZ-1:0]     off_i,
  input  logic [NZ-1:0]     heat_i,
  input  logic [NZ-1:0]     cool_i,
  input  logic [NZ*TW-1:0]  temp_i,
  input  logic [NZ*TW-1:0]  setpt_i,
  output logic [NZ-1:0]     power_o,
  output logic [NZ-1:0]     heat_o,
  output logic [NZ-1:0]     cool_o,
  output logic [NZ-1:0]     fan_o,
  output logic [NZ*3-1:0]   state_o
);

  localparam int unsigned CNT_SPAN = (MIN_RUN > LOCKOUT) ? MIN_RUN : LOCKOUT;
  localparam int unsigned CW       = $clog2(CNT_SPAN + 1);
  localparam int unsigned XW       = TW + 1;

  localparam logic [XW-1:0] HYST_X    = XW'(HYST);
  localparam logic [XW-1:0] TMAX_X    = {1'b0, {TW{1'b1}}};
  localparam logic [CW-1:0] RUN_LAST  = CW'(MIN_RUN - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCKOUT - 1);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_IDLE    = 3'd1,
    ST_HEATING = 3'd2,
    ST_COOLING = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  typedef enum logic {
    MODE_HEAT = 1'b0,
    MODE_COOL = 1'b1
  } mode_e;

  for (genvar z = 0; z < NZ; z++) begin : g_zone
    state_e        state, state_nxt;
    mode_e         mode, mode_nxt;
    logic          pend, pend_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          power_q, heat_q, cool_q, fan_q;
    logic          power_nxt, heat_nxt, cool_nxt, fan_nxt;
    logic [XW-1:0] temp_x, setpt_x, lo_x, hi_x;
    logic          run_done, lock_done;

    assign temp_x  = {1'b0, temp_i[z*TW +: TW]};
    assign setpt_x = {1'b0, setpt_i[z*TW +: TW]};

    // Hysteresis thresholds, saturating at the ends of the TW-bit range
    always_comb begin
      lo_x = '0;
      hi_x = TMAX_X;
      if (setpt_x > HYST_X) lo_x = setpt_x - HYST_X;
      if ((setpt_x + HYST_X) < TMAX_X) hi_x = setpt_x + HYST_X;
    end

    // One dwell counter serves as run_cnt in HEATING/COOLING and lock_cnt in
    // LOCKOUT; it clears on every state change.
    assign run_done  = (cnt >= RUN_LAST);
    assign lock_done = (cnt >= LOCK_LAST);

    // Next-state, mode, pending-off, counter and output decode
    always_comb begin
      state_nxt = state;
      mode_nxt  = mode;
      pend_nxt  = 1'b0;
      cnt_nxt   = cnt;

      if (cool_i[z])      mode_nxt = MODE_COOL;
      else if (heat_i[z]) mode_nxt = MODE_HEAT;

      unique case (state)
        ST_OFF: begin
          if (on_i[z] && !off_i[z]) state_nxt = ST_IDLE;
        end
        ST_IDLE: begin
          // Uses the mode held before this cycle's mode command
          if (off_i[z])                                    state_nxt = ST_OFF;
          else if (mode == MODE_HEAT && temp_x <= lo_x)    state_nxt = ST_HEATING;
          else if (mode == MODE_COOL && temp_x >= hi_x)    state_nxt = ST_COOLING;
        end
        ST_HEATING: begin
          if (off_i[z]) begin
            state_nxt = ST_LOCKOUT;
            pend_nxt  = 1'b1;
          end else if (run_done && (temp_x >= setpt_x || mode != MODE_HEAT)) begin
            state_nxt = ST_LOCKOUT;
          end
        end
        ST_COOLING: begin
          if (off_i[z]) begin
            state_nxt = ST_LOCKOUT;
            pend_nxt  = 1'b1;
          end else if (run_done && (temp_x <= setpt_x || mode != MODE_COOL)) begin
            state_nxt = ST_LOCKOUT;
          end
        end
        ST_LOCKOUT: begin
          // off beats on when both arrive together
          if (off_i[z])     pend_nxt = 1'b1;
          else if (on_i[z]) pend_nxt = 1'b0;
          else              pend_nxt = pend;
          if (lock_done) state_nxt = pend_nxt ? ST_OFF : ST_IDLE;
        end
        default: state_nxt = ST_OFF;
      endcase

      if (state_nxt != state)  cnt_nxt = '0;
      else if (cnt != '1)      cnt_nxt = cnt + CW'(1);

      power_nxt = (state_nxt != ST_OFF);
      heat_nxt  = (state_nxt == ST_HEATING);
      cool_nxt  = (state_nxt == ST_COOLING);
      fan_nxt   = (state_nxt == ST_HEATING) || (state_nxt == ST_COOLING) ||
                  (state_nxt == ST_LOCKOUT);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state   <= ST_OFF;
        mode    <= MODE_HEAT;
        pend    <= 1'b0;
        cnt     <= '0;
        power_q <= 1'b0;
        heat_q  <= 1'b0;
        cool_q  <= 1'b0;
        fan_q   <= 1'b0;
      end else begin
        state   <= state_nxt;
        mode    <= mode_nxt;
        pend    <= pend_nxt;
        cnt     <= cnt_nxt;
        power_q <= power_nxt;
        heat_q  <= heat_nxt;
        cool_q  <= cool_nxt;
        fan_q   <= fan_nxt;
      end
    end

    assign power_o[z]        = power_q;
    assign heat_o[z]         = heat_q;
    assign cool_o[z]         = cool_q;
    assign fan_o[z]          = fan_q;
    assign state_o[z*3 +: 3] = state;
  end

endmodule
